wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 48 ++++
 rtl/wb_load_align.sv | 37 +++
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage and its decode-side users.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_stage_pkg;

    // Load size encodings; any value above LD_WORD is also a full word.
    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    // Register 0 is hardwired: writes to it are consumed and dropped.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Register aliases shared with decode.
    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] AT   = 5'd1;
    localparam logic [4:0] V0   = 5'd2;
    localparam logic [4:0] V1   = 5'd3;
    localparam logic [4:0] A0   = 5'd4;
    localparam logic [4:0] A1   = 5'd5;
    localparam logic [4:0] A2   = 5'd6;
    localparam logic [4:0] A3   = 5'd7;
    localparam logic [4:0] T0   = 5'd8;
    localparam logic [4:0] T1   = 5'd9;
    localparam logic [4:0] T2   = 5'd10;
    localparam logic [4:0] T3   = 5'd11;
    localparam logic [4:0] T4   = 5'd12;
    localparam logic [4:0] T5   = 5'd13;
    localparam logic [4:0] T6   = 5'd14;
    localparam logic [4:0] T7   = 5'd15;
    localparam logic [4:0] S0   = 5'd16;
    localparam logic [4:0] S1   = 5'd17;
    localparam logic [4:0] S2   = 5'd18;
    localparam logic [4:0] S3   = 5'd19;
    localparam logic [4:0] S4   = 5'd20;
    localparam logic [4:0] S5   = 5'd21;
    localparam logic [4:0] S6   = 5'd22;
    localparam logic [4:0] S7   = 5'd23;
    localparam logic [4:0] T8   = 5'd24;
    localparam logic [4:0] T9   = 5'd25;
    localparam logic [4:0] K0   = 5'd26;
    localparam logic [4:0] K1   = 5'd27;
    localparam logic [4:0] GP   = 5'd28;
    localparam logic [4:0] SP   = 5'd29;
    localparam logic [4:0] FP   = 5'd30;
    localparam logic [4:0] RA   = 5'd31;

endpackage

// File: rtl/wb_load_align.sv
// Little-endian lane select plus sign/zero extension of a raw load word.
// Latency: purely combinational.
// Backpressure: none.
module wb_load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic [31:0] aligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lanes, then extend according to size and signedness.
    always_comb begin
        byte_lane = ld_word[7:0];
        case (ld_addr_lo)
            2'd0: byte_lane = ld_word[7:0];
            2'd1: byte_lane = ld_word[15:8];
            2'd2: byte_lane = ld_word[23:16];
            default: byte_lane = ld_word[31:24];
        endcase
        // Halfword alignment ignores address bit 0.
        half_lane = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        aligned = ld_word;
        if (ld_size == LD_BYTE) begin
            aligned = {{24{ld_signed & byte_lane[7]}}, byte_lane};
        end else if (ld_size == LD_HALF) begin
            aligned = {{16{ld_signed & half_lane[15]}}, half_lane};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback merge of ALU and load results into one registered regfile write.
// Latency: 1 cycle from acceptance to write; a load colliding with ALU waits in hold.
// Backpressure: ALU never stalls; ld_ready drops while the one-entry hold is full.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_dst,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_dst,
    input  logic [DW-1:0] ld_word,
    input  logic [1:0]    ld_addr_lo,
    input  logic [1:0]    ld_size,
    input  logic          ld_signed,
    input  logic [AW-1:0] chk_reg0,
    input  logic [AW-1:0] chk_reg1,
    output logic          hazard,
    output logic          reg_wren,
    output logic [AW-1:0] w_reg0,
    output logic [DW-1:0] w_data
);

    logic          wren_q, wren_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          hold_vld_q, hold_vld_d;
    logic [AW-1:0] hold_dst_q, hold_dst_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    logic [DW-1:0] ld_aligned;
    logic          ld_xfer;
    logic          ld_live;
    logic          alu_take;

    // Alignment happens at transfer so the hold buffer stores final data.
    wb_load_align u_align (
        .ld_word    (ld_word),
        .ld_addr_lo (ld_addr_lo),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .aligned    (ld_aligned)
    );

    assign ld_ready = !hold_vld_q;
    assign ld_xfer  = ld_valid && ld_ready;
    assign ld_live  = ld_xfer && (ld_dst != REG_ZERO);
    assign alu_take = alu_valid && (alu_dst != REG_ZERO);

    // Arbitrate ALU > held entry > new load into the output slot.
    always_comb begin
        wren_d      = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        hold_vld_d  = hold_vld_q;
        hold_dst_d  = hold_dst_q;
        hold_data_d = hold_data_q;
        if (alu_take) begin
            wren_d  = 1'b1;
            wreg_d  = alu_dst;
            wdata_d = alu_data;
            // A load can only transfer when hold is empty, so it never overwrites.
            if (ld_live) begin
                hold_vld_d  = 1'b1;
                hold_dst_d  = ld_dst;
                hold_data_d = ld_aligned;
            end
        end else if (hold_vld_q) begin
            wren_d     = 1'b1;
            wreg_d     = hold_dst_q;
            wdata_d    = hold_data_q;
            hold_vld_d = 1'b0;
        end else if (ld_live) begin
            wren_d  = 1'b1;
            wreg_d  = ld_dst;
            wdata_d = ld_aligned;
        end
    end

    // Output slot and hold buffer state; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wren_q      <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            hold_vld_q  <= 1'b0;
            hold_dst_q  <= '0;
            hold_data_q <= '0;
        end else begin
            wren_q      <= wren_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
            hold_vld_q  <= hold_vld_d;
            hold_dst_q  <= hold_dst_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Register 0 is never a real dependency, so it never raises hazard.
    always_comb begin
        hazard = 1'b0;
        if (chk_reg0 != REG_ZERO) begin
            hazard = hazard || (hold_vld_q && hold_dst_q == chk_reg0)
                            || (wren_q && wreg_q == chk_reg0);
        end
        if (chk_reg1 != REG_ZERO) begin
            hazard = hazard || (hold_vld_q && hold_dst_q == chk_reg1)
                            || (wren_q && wreg_q == chk_reg1);
        end
    end

    assign reg_wren = wren_q;
    assign w_reg0   = wreg_q;
    assign w_data   = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes are queued with their due cycle.
// Latency: checks the exact cycle each regfile write appears.
// Backpressure: exercises hold-full stalls, ALU priority and reset while held.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dst;
    logic [31:0] ld_word;
    logic [1:0]  ld_addr_lo;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [4:0]  chk_reg0;
    logic [4:0]  chk_reg1;
    logic        hazard;
    logic        reg_wren;
    logic [4:0]  w_reg0;
    logic [31:0] w_data;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wb_stage #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_dst    (alu_dst),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_dst     (ld_dst),
        .ld_word    (ld_word),
        .ld_addr_lo (ld_addr_lo),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .chk_reg0   (chk_reg0),
        .chk_reg1   (chk_reg1),
        .hazard     (hazard),
        .reg_wren   (reg_wren),
        .w_reg0     (w_reg0),
        .w_data     (w_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        alu_dst    = 5'd0;
        alu_data   = 32'd0;
        ld_valid   = 1'b0;
        ld_dst     = 5'd0;
        ld_word    = 32'd0;
        ld_addr_lo = 2'd0;
        ld_size    = 2'd0;
        ld_signed  = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] dst, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_dst   = dst;
        alu_data  = data;
    endtask

    task automatic drive_ld(input logic [4:0] dst, input logic [31:0] w, input logic [1:0] a,
                            input logic [1:0] sz, input logic sg);
        ld_valid   = 1'b1;
        ld_dst     = dst;
        ld_word    = w;
        ld_addr_lo = a;
        ld_size    = sz;
        ld_signed  = sg;
    endtask

    task automatic expect_wr(input logic [4:0] dst, input logic [31:0] data, input int due);
        exp_t e;
        e.dst  = dst;
        e.data = data;
        e.cyc  = due;
        exp_q.push_back(e);
    endtask

    // Monitor: every regfile write must match the head of the queue, on its due cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reg_wren === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got r%0d=0x%08h at cycle %0d, expected no write",
                             w_reg0, w_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (w_reg0 !== e.dst || w_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write: got r%0d=0x%08h at cycle %0d, expected r%0d=0x%08h at cycle %0d",
                                 w_reg0, w_data, cyc, e.dst, e.data, e.cyc);
                    end
                end
            end
        end
    end

    // Directed load alignment vectors with hand-computed results.
    logic [31:0] tv_word [9] = '{32'h8000FFFF, 32'h8000FFFF, 32'h80FF7F01, 32'h80FF7F01,
                                 32'h80FF7F01, 32'h1234F678, 32'hCAFEBABE, 32'h8765ABCD,
                                 32'h80FF7F01};
    logic [1:0]  tv_addr [9] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0};
    logic [1:0]  tv_size [9] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic        tv_sgn  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] tv_exp  [9] = '{32'hFFFF8000, 32'h00008000, 32'h00000080, 32'hFFFFFF80,
                                 32'hFFFFFFFF, 32'hFFFFF678, 32'hCAFEBABE, 32'h8765ABCD,
                                 32'h00000001};

    initial begin
        reset    = 1'b1;
        chk_reg0 = 5'd0;
        chk_reg1 = 5'd0;
        idle();

        // Reset held two cycles, then released.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wren", {31'd0, reg_wren}, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        for (int i = 0; i < 32; i += 7) begin
            chk_reg0 = 5'(i);
            chk_reg1 = 5'(31 - i);
            #0.1;
            chk("rst_hazard", {31'd0, hazard}, 32'd0);
        end

        // Single ALU write, then nothing.
        next_cycle();
        drive_alu(5'd5, 32'h12345678);
        expect_wr(5'd5, 32'h12345678, cyc + 1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("alu_write_wren", {31'd0, reg_wren}, 32'd1);
        next_cycle();
        chk("alu_after_idle_wren", {31'd0, reg_wren}, 32'd0);

        // ALU and load collide: load waits one cycle in hold.
        drive_alu(5'd8, 32'h0000000A);
        drive_ld(5'd9, 32'h80FF7F01, 2'd1, 2'd0, 1'b1);
        expect_wr(5'd8, 32'h0000000A, cyc + 1);
        expect_wr(5'd9, 32'h0000007F, cyc + 2);
        next_cycle();
        idle();
        chk_reg0 = 5'd9;
        chk_reg1 = 5'd0;
        @(negedge clk);
        chk("collide_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("collide_hazard_hold", {31'd0, hazard}, 32'd1);
        chk_reg0 = 5'd0;
        chk_reg1 = 5'd8;
        #1;
        chk("collide_hazard_slot", {31'd0, hazard}, 32'd1);
        chk_reg1 = 5'd7;
        #1;
        chk("collide_hazard_other", {31'd0, hazard}, 32'd0);
        chk_reg0 = 5'd9;
        next_cycle();
        chk("drain_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("drain_hazard_slot", {31'd0, hazard}, 32'd1);
        next_cycle();
        chk("drained_hazard", {31'd0, hazard}, 32'd0);

        // ALU keeps priority over a held load for two cycles; a load offered
        // while not ready must be ignored.
        drive_alu(5'd12, 32'hAAAA0012);
        drive_ld(5'd14, 32'h0BADF00D, 2'd0, 2'd2, 1'b0);
        expect_wr(5'd12, 32'hAAAA0012, cyc + 1);
        expect_wr(5'd13, 32'hAAAA0013, cyc + 2);
        expect_wr(5'd14, 32'h0BADF00D, cyc + 3);
        next_cycle();
        drive_alu(5'd13, 32'hAAAA0013);
        drive_ld(5'd15, 32'h55555555, 2'd0, 2'd2, 1'b0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("alu_prio_ld_ready", {31'd0, ld_ready}, 32'd0);
        next_cycle();
        next_cycle();

        // Back-to-back loads through the alignment table, ALU idle.
        for (int i = 0; i < 9; i++) begin
            drive_ld(5'(16 + i), tv_word[i], tv_addr[i], tv_size[i], tv_sgn[i]);
            expect_wr(5'(16 + i), tv_exp[i], cyc + 1);
            next_cycle();
        end
        idle();
        next_cycle();

        // Destination 0 on both paths is swallowed.
        drive_alu(5'd0, 32'h0000DEAD);
        drive_ld(5'd0, 32'hFFFFFFFF, 2'd0, 2'd2, 1'b1);
        chk_reg0 = 5'd0;
        chk_reg1 = 5'd0;
        next_cycle();
        idle();
        @(negedge clk);
        chk("zero_dst_wren", {31'd0, reg_wren}, 32'd0);
        chk("zero_dst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("zero_dst_hazard", {31'd0, hazard}, 32'd0);
        next_cycle();

        // Hold full with a load for r3, then reset drops it.
        drive_alu(5'd4, 32'h00000044);
        drive_ld(5'd3, 32'h33333333, 2'd0, 2'd2, 1'b0);
        expect_wr(5'd4, 32'h00000044, cyc + 1);
        next_cycle();
        idle();
        reset = 1'b1;
        chk_reg0 = 5'd3;
        @(negedge clk);
        chk("pre_reset_ld_ready", {31'd0, ld_ready}, 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_wren", {31'd0, reg_wren}, 32'd0);
        chk("post_reset_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("post_reset_hazard", {31'd0, hazard}, 32'd0);
        repeat (4) next_cycle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
